vram_blit_master: RTL and testbench

Avalon-MM initiator that copies a run of 32-bit words from a source address to a destination address on the same fabric, so software can move glyph/sprite data into the VGA text and sprite VRAM windows without CPU load/store loops. It is the master-side counterpart of the VGA Avalon-MM slave. It sits on the Platform Designer bus next to the CPU, behind a small command port driven by a CSR shim or the CPU directly.

---
 rtl/vram_blit_pkg.sv | 22 ++
 rtl/vram_blit_master.sv | 188 ++++++++++++++++++
 tb/tb_vram_blit_master.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_blit_pkg.sv
// Shared types and constants for the VRAM blit master.
//   state_t      : blit FSM states
//   DEF_ADDR_W   : default word-address width
//   DEF_LEN_W    : default word-count width
//   BYTE_EN_ALL  : byte enables driven while a request is active
package vram_blit_pkg;

   localparam int unsigned DEF_ADDR_W = 12;
   localparam int unsigned DEF_LEN_W  = 12;
   localparam int unsigned DATA_W     = 32;

   localparam logic [3:0] BYTE_EN_ALL = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      DONE
   } state_t;

endpackage

// File: rtl/vram_blit_master.sv
// Avalon-MM initiator that copies CMD_LEN 32-bit words from CMD_SRC to
// CMD_DST in strictly ascending order, one outstanding read at a time.
// Optional fill mode (macro VRAM_BLIT_FILL_EN) writes a constant word to
// the destination range without reading.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   CMD_START             start strobe, sampled only in IDLE
//   CMD_SRC/DST/LEN       command, latched on an accepted start
//   CMD_FILL/FILL_DATA    fill select and fill word (VRAM_BLIT_FILL_EN only)
//   BUSY, DONE            status; DONE is a one-cycle pulse
//   AVM_*                 Avalon-MM master, pipelined reads
module vram_blit_master
   import vram_blit_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CMD_START,
   input  logic [ADDR_W-1:0] CMD_SRC,
   input  logic [ADDR_W-1:0] CMD_DST,
   input  logic [LEN_W-1:0]  CMD_LEN,
`ifdef VRAM_BLIT_FILL_EN
   input  logic              CMD_FILL,
   input  logic [31:0]       CMD_FILL_DATA,
`endif
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] AVM_ADDR,
   output logic              AVM_READ,
   output logic              AVM_WRITE,
   output logic [3:0]        AVM_BYTE_EN,
   output logic [31:0]       AVM_WRITEDATA,
   input  logic [31:0]       AVM_READDATA,
   input  logic              AVM_WAITREQUEST,
   input  logic              AVM_READDATAVALID
);

   state_t              state, state_n;
   logic [ADDR_W-1:0]   src_ptr, src_n;
   logic [ADDR_W-1:0]   dst_ptr, dst_n;
   logic [LEN_W-1:0]    remaining, rem_n;
   logic                fill_q, fill_n;
   logic                busy_n, done_n, read_n, write_n;
   logic [ADDR_W-1:0]   addr_n;
   logic [3:0]          be_n;
   logic [31:0]         wdata_n;
   logic                fill_sel_c;
   logic [31:0]         fill_word_c;

   // Fill-mode command inputs; tied off in the copy-only build
`ifdef VRAM_BLIT_FILL_EN
   assign fill_sel_c  = CMD_FILL;
   assign fill_word_c = CMD_FILL_DATA;
`else
   assign fill_sel_c  = 1'b0;
   assign fill_word_c = 32'h0;
`endif

   // State, command latches and registered bus outputs.
   // AVM_WRITEDATA doubles as the read-data holding register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state         <= IDLE;
         src_ptr       <= '0;
         dst_ptr       <= '0;
         remaining     <= '0;
         fill_q        <= 1'b0;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         AVM_ADDR      <= '0;
         AVM_READ      <= 1'b0;
         AVM_WRITE     <= 1'b0;
         AVM_BYTE_EN   <= '0;
         AVM_WRITEDATA <= '0;
      end else begin
         state         <= state_n;
         src_ptr       <= src_n;
         dst_ptr       <= dst_n;
         remaining     <= rem_n;
         fill_q        <= fill_n;
         BUSY          <= busy_n;
         DONE          <= done_n;
         AVM_ADDR      <= addr_n;
         AVM_READ      <= read_n;
         AVM_WRITE     <= write_n;
         AVM_BYTE_EN   <= be_n;
         AVM_WRITEDATA <= wdata_n;
      end
   end

   // Next state and next registered outputs; everything holds by default,
   // which keeps the bus stable while the slave stalls.
   always_comb begin
      state_n = state;
      src_n   = src_ptr;
      dst_n   = dst_ptr;
      rem_n   = remaining;
      fill_n  = fill_q;
      busy_n  = BUSY;
      done_n  = 1'b0;
      addr_n  = AVM_ADDR;
      read_n  = AVM_READ;
      write_n = AVM_WRITE;
      be_n    = AVM_BYTE_EN;
      wdata_n = AVM_WRITEDATA;

      unique case (state)
         IDLE: begin
            if (CMD_START) begin
               src_n  = CMD_SRC;
               dst_n  = CMD_DST;
               rem_n  = CMD_LEN;
               fill_n = fill_sel_c;
               if (CMD_LEN == '0) begin
                  done_n  = 1'b1;
                  state_n = vram_blit_pkg::DONE;
               end else if (fill_sel_c) begin
                  busy_n  = 1'b1;
                  write_n = 1'b1;
                  addr_n  = CMD_DST;
                  be_n    = BYTE_EN_ALL;
                  wdata_n = fill_word_c;
                  state_n = WR_REQ;
               end else begin
                  busy_n  = 1'b1;
                  read_n  = 1'b1;
                  addr_n  = CMD_SRC;
                  be_n    = BYTE_EN_ALL;
                  state_n = RD_REQ;
               end
            end
         end

         RD_REQ: begin
            if (!AVM_WAITREQUEST) begin
               read_n  = 1'b0;
               be_n    = '0;
               src_n   = src_ptr + ADDR_W'(1);
               state_n = RD_WAIT;
            end
         end

         RD_WAIT: begin
            if (AVM_READDATAVALID) begin
               wdata_n = AVM_READDATA;
               write_n = 1'b1;
               addr_n  = dst_ptr;
               be_n    = BYTE_EN_ALL;
               state_n = WR_REQ;
            end
         end

         WR_REQ: begin
            if (!AVM_WAITREQUEST) begin
               dst_n = dst_ptr + ADDR_W'(1);
               rem_n = remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) begin
                  write_n = 1'b0;
                  be_n    = '0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = vram_blit_pkg::DONE;
               end else if (fill_q) begin
                  // back-to-back writes, fill word stays in the data register
                  addr_n = dst_ptr + ADDR_W'(1);
               end else begin
                  write_n = 1'b0;
                  read_n  = 1'b1;
                  addr_n  = src_ptr;
                  state_n = RD_REQ;
               end
            end
         end

         vram_blit_pkg::DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_vram_blit_master.sv
// Directed bench for vram_blit_master with an Avalon slave memory model
// (random waitrequest, configurable readdatavalid latency) and a write
// scoreboard fed when each command is issued.
module tb_vram_blit_master;

   logic        CLK;
   logic        RESET;
   logic        CMD_START;
   logic [11:0] CMD_SRC;
   logic [11:0] CMD_DST;
   logic [11:0] CMD_LEN;
`ifdef VRAM_BLIT_FILL_EN
   logic        CMD_FILL;
   logic [31:0] CMD_FILL_DATA;
`endif
   logic        BUSY;
   logic        DONE;
   logic [11:0] AVM_ADDR;
   logic        AVM_READ;
   logic        AVM_WRITE;
   logic [3:0]  AVM_BYTE_EN;
   logic [31:0] AVM_WRITEDATA;
   logic [31:0] AVM_READDATA;
   logic        AVM_WAITREQUEST;
   logic        AVM_READDATAVALID;

   vram_blit_master dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .CMD_START         (CMD_START),
      .CMD_SRC           (CMD_SRC),
      .CMD_DST           (CMD_DST),
      .CMD_LEN           (CMD_LEN),
`ifdef VRAM_BLIT_FILL_EN
      .CMD_FILL          (CMD_FILL),
      .CMD_FILL_DATA     (CMD_FILL_DATA),
`endif
      .BUSY              (BUSY),
      .DONE              (DONE),
      .AVM_ADDR          (AVM_ADDR),
      .AVM_READ          (AVM_READ),
      .AVM_WRITE         (AVM_WRITE),
      .AVM_BYTE_EN       (AVM_BYTE_EN),
      .AVM_WRITEDATA     (AVM_WRITEDATA),
      .AVM_READDATA      (AVM_READDATA),
      .AVM_WAITREQUEST   (AVM_WAITREQUEST),
      .AVM_READDATAVALID (AVM_READDATAVALID)
   );

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   typedef struct {
      logic [11:0] a;
      logic [31:0] d;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [0:4095];

   int checks = 0;
   int errors = 0;

   // slave model knobs and observations
   logic        stall_en   = 1'b0;
   logic        force_wait = 1'b0;
   int          lat_min    = 1;
   int          lat_max    = 1;
   int          pend       = 0;
   logic [11:0] pend_addr  = '0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_bus   = '0;
   logic        model_wr;
   int          ncyc = 0;
   int          reads = 0, writes = 0, done_count = 0, busy_cycles = 0, rdv_cnt = 0;
   int          done_cyc = 0, start_ncyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Avalon slave + bus monitor, evaluated mid-cycle
   always @(negedge CLK) begin
      exp_t e;
      logic ev;
      ncyc++;
      if (prev_stall && !RESET)
         chk("stable_under_wait",
             {14'h0, AVM_ADDR, AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA}, prev_bus);

      AVM_READDATAVALID = 1'b0;
      AVM_READDATA      = 32'h0;
      if (pend != 0) begin
         pend--;
         if (pend == 0) begin
            AVM_READDATAVALID = 1'b1;
            AVM_READDATA      = mem[pend_addr];
            rdv_cnt++;
         end
      end
      if (pend != 0 || AVM_READDATAVALID)
         chk("read_while_outstanding", 64'(AVM_READ), 64'h0);

      model_wr = force_wait ? 1'b1 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b0);
      AVM_WAITREQUEST = model_wr;

      if (!model_wr && !RESET && AVM_READ) begin
         reads++;
         chk("read_byte_en", 64'(AVM_BYTE_EN), 64'hF);
         pend      = int'($urandom_range(lat_min, lat_max));
         pend_addr = AVM_ADDR;
      end
      if (!model_wr && !RESET && AVM_WRITE) begin
         writes++;
         chk("write_byte_en", 64'(AVM_BYTE_EN), 64'hF);
         ev = 1'b0;
         e  = '{a: 12'h0, d: 32'h0};
         if (sb.size() != 0) begin
            e  = sb.pop_front();
            ev = 1'b1;
         end
         chk("write_addr", {51'h0, ev, AVM_ADDR}, {51'h0, 1'b1, e.a});
         chk("write_data", 64'(AVM_WRITEDATA), 64'(e.d));
         mem[AVM_ADDR] = AVM_WRITEDATA;
      end
      prev_stall = model_wr && !RESET && (AVM_READ || AVM_WRITE);
      prev_bus   = {14'h0, AVM_ADDR, AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA};
      if (DONE) begin
         done_count++;
         done_cyc = ncyc;
      end
      if (BUSY) busy_cycles++;
   end

   task automatic push_copy(input logic [11:0] src, input logic [11:0] dst, input int len);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.a = 12'(dst + 12'(i));
         e.d = mem[12'(src + 12'(i))];
         sb.push_back(e);
      end
   endtask

   // one-cycle start; command inputs are scrambled afterwards
   task automatic do_start(input logic [11:0] src, input logic [11:0] dst, input logic [11:0] len);
      @(negedge CLK); #1;
      reads = 0; writes = 0; done_count = 0; busy_cycles = 0; rdv_cnt = 0;
      CMD_SRC = src; CMD_DST = dst; CMD_LEN = len; CMD_START = 1'b1;
      start_ncyc = ncyc;
      @(negedge CLK); #1;
      CMD_START = 1'b0;
      CMD_SRC = 12'($urandom); CMD_DST = 12'($urandom); CMD_LEN = 12'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_count == 0 && n < budget) begin
         @(negedge CLK); #1;
         n++;
      end
      chk("done_seen", 64'(done_count != 0), 64'h1);
      repeat (3) @(negedge CLK);
      #1;
   endtask

   initial begin
      int n;
      exp_t e;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      RESET = 1'b1; CMD_START = 1'b0; CMD_SRC = '0; CMD_DST = '0; CMD_LEN = '0;
`ifdef VRAM_BLIT_FILL_EN
      CMD_FILL = 1'b0; CMD_FILL_DATA = 32'h0;
`endif
      AVM_WAITREQUEST = 1'b0; AVM_READDATAVALID = 1'b0; AVM_READDATA = 32'h0;

      // reset values
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_busy",  64'(BUSY), 64'h0);
      chk("rst_done",  64'(DONE), 64'h0);
      chk("rst_read",  64'(AVM_READ), 64'h0);
      chk("rst_write", 64'(AVM_WRITE), 64'h0);
      chk("rst_addr",  64'(AVM_ADDR), 64'h0);
      chk("rst_be",    64'(AVM_BYTE_EN), 64'h0);
      chk("rst_wdata", 64'(AVM_WRITEDATA), 64'h0);
      RESET = 1'b0;

      // zero-wait copy, 3 cycles per word
      push_copy(12'h100, 12'h000, 4);
      do_start(12'h100, 12'h000, 12'd4);
      wait_done(100);
      chk("t1_done_lat", 64'(done_cyc - start_ncyc), 64'd13);
      chk("t1_busy_cyc", 64'(busy_cycles), 64'd12);
      chk("t1_done_cnt", 64'(done_count), 64'd1);
      chk("t1_reads",    64'(reads), 64'd4);
      chk("t1_writes",   64'(writes), 64'd4);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // zero length
      do_start(12'h123, 12'h456, 12'd0);
      wait_done(10);
      chk("len0_done_lat", 64'(done_cyc - start_ncyc), 64'd1);
      chk("len0_reads",    64'(reads), 64'd0);
      chk("len0_writes",   64'(writes), 64'd0);
      chk("len0_busy",     64'(busy_cycles), 64'd0);
      chk("len0_done_cnt", 64'(done_count), 64'd1);

      // destination wrap
      push_copy(12'h300, 12'hFFE, 4);
      do_start(12'h300, 12'hFFE, 12'd4);
      wait_done(100);
      chk("wrap_writes",   64'(writes), 64'd4);
      chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

      // random stalls and latency, plus an ignored start while busy
      stall_en = 1'b1; lat_min = 1; lat_max = 4;
      push_copy(12'h200, 12'h800, 600);
      do_start(12'h200, 12'h800, 12'd600);
      repeat (30) @(negedge CLK);
      #1;
      CMD_SRC = 12'h000; CMD_DST = 12'h900; CMD_LEN = 12'd5; CMD_START = 1'b1;
      @(negedge CLK); #1;
      CMD_START = 1'b0;
      wait_done(20000);
      chk("rand_reads",    64'(reads), 64'd600);
      chk("rand_writes",   64'(writes), 64'd600);
      chk("rand_done_cnt", 64'(done_count), 64'd1);
      chk("rand_sb_empty", 64'(sb.size()), 64'd0);
      stall_en = 1'b0; lat_min = 1; lat_max = 1;
      repeat (6) @(negedge CLK);
      #1;

      // reset while waiting for the second word's read data
      lat_min = 4; lat_max = 4;
      e.a = 12'h500; e.d = mem[12'h400];
      sb.push_back(e);
      do_start(12'h400, 12'h500, 12'd5);
      n = 0;
      while (reads < 2 && n < 200) begin
         @(negedge CLK); #1;
         n++;
      end
      chk("rst_rd2_reached", 64'(reads), 64'd2);
      @(negedge CLK); #1;
      RESET = 1'b1;
      #1;
      chk("mid_rst_read",  64'(AVM_READ), 64'h0);
      chk("mid_rst_write", 64'(AVM_WRITE), 64'h0);
      chk("mid_rst_busy",  64'(BUSY), 64'h0);
      repeat (2) @(negedge CLK);
      #1;
      RESET = 1'b0;
      repeat (8) @(negedge CLK);
      #1;
      chk("post_rst_writes", 64'(writes), 64'd1);
      chk("post_rst_done",   64'(done_count), 64'd0);
      chk("post_rst_rdv",    64'(rdv_cnt), 64'd2);
      chk("post_rst_sb",     64'(sb.size()), 64'd0);

      // reset while a write is stalled
      lat_min = 1; lat_max = 1;
      do_start(12'h400, 12'h600, 12'd2);
      n = 0;
      while (reads < 1 && n < 50) begin
         @(negedge CLK); #1;
         n++;
      end
      force_wait = 1'b1;
      repeat (5) @(negedge CLK);
      #1;
      chk("held_write",      64'(AVM_WRITE), 64'h1);
      chk("held_write_addr", 64'(AVM_ADDR), 64'h600);
      RESET = 1'b1;
      #1;
      chk("wr_rst_write", 64'(AVM_WRITE), 64'h0);
      chk("wr_rst_addr",  64'(AVM_ADDR), 64'h0);
      repeat (2) @(negedge CLK);
      #1;
      RESET = 1'b0;
      force_wait = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      chk("wr_rst_writes", 64'(writes), 64'd0);
      chk("wr_rst_done",   64'(done_count), 64'd0);

      // normal operation after reset
      push_copy(12'h410, 12'h610, 3);
      do_start(12'h410, 12'h610, 12'd3);
      wait_done(100);
      chk("recov_done_lat", 64'(done_cyc - start_ncyc), 64'd10);
      chk("recov_writes",   64'(writes), 64'd3);
      chk("recov_sb_empty", 64'(sb.size()), 64'd0);

`ifdef VRAM_BLIT_FILL_EN
      // fill mode: writes only, one cycle per word
      CMD_FILL = 1'b1; CMD_FILL_DATA = 32'h20202020;
      for (int i = 0; i < 3; i++) begin
         e.a = 12'(12'h010 + 12'(i));
         e.d = 32'h20202020;
         sb.push_back(e);
      end
      do_start(12'h7AB, 12'h010, 12'd3);
      CMD_FILL = 1'b0; CMD_FILL_DATA = 32'hDEADBEEF;
      wait_done(50);
      chk("fill_done_lat", 64'(done_cyc - start_ncyc), 64'd4);
      chk("fill_reads",    64'(reads), 64'd0);
      chk("fill_writes",   64'(writes), 64'd3);
      chk("fill_busy",     64'(busy_cycles), 64'd3);
      chk("fill_sb_empty", 64'(sb.size()), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
